// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: round count, RCON table, byte/word layout.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int CNT_W      = 4;

  // Word i lives at bits [32i+31:32i]; byte j of a word at [8j+7:8j].
  // Byte 0 of word 0 is key_in[7:0].
  localparam logic [9:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kx_state_e;

  // rcon for round r (1..10); zero outside that range.
  function automatic logic [BYTE_W-1:0] rcon_of(input logic [CNT_W-1:0] r);
    logic [BYTE_W-1:0] v;
    v = '0;
    for (int i = 0; i < 10; i++)
      if (r == CNT_W'(i + 1)) v = RCON[i];
    return v;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule round: next round key from the previous one and rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0]  rk_i,
  input  logic [BYTE_W-1:0] rcon_i,
  output logic [KEY_W-1:0]  rk_o
);

  logic [WORD_W-1:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

  assign w0 = rk_i[0*WORD_W +: WORD_W];
  assign w1 = rk_i[1*WORD_W +: WORD_W];
  assign w2 = rk_i[2*WORD_W +: WORD_W];
  assign w3 = rk_i[3*WORD_W +: WORD_W];

  // RotWord with byte 0 in the low bits: byte 1 moves down to byte 0.
  assign rot = {w3[7:0], w3[31:8]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (rot[g*BYTE_W +: BYTE_W]),
      .byte_o (sub[g*BYTE_W +: BYTE_W])
    );
  end

  // Word chain of the AES-128 schedule; rcon hits byte 0 only.
  always_comb begin
    t    = sub ^ {24'h0, rcon_i};
    n0   = w0 ^ t;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    rk_o = {n3, n2, n1, n0};
  end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Addition chain to x^254; zero maps to zero, as the S-box definition needs.
  always_comb begin
    x2   = gf_mul(byte_i, byte_i);
    x3   = gf_mul(x2, byte_i);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, byte_i);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, byte_i);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, byte_i);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, byte_i);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, byte_i);
    inv  = gf_mul(x127, x127);
    byte_o = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule with an 11-entry round-key store and a
// combinational forward/reverse read port for the round datapath.
module aes_key_expander #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS  // only 10 is supported
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  input  logic         rd_dec,
  output logic [127:0] rd_key
);

  localparam int NE = NUM_ROUNDS + 1;

  aes_pkg::kx_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] store_q [NE];
  logic [127:0] store_d [NE];
  logic [127:0] step_in, step_out;
  logic [3:0]   eff_idx;

  // Previous round key for the current counter value (cnt-1).
  always_comb begin
    step_in = '0;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (cnt_q == 4'(i + 1)) step_in = store_q[i];
  end

  aes_key_step u_step (
    .rk_i   (step_in),
    .rcon_i (aes_pkg::rcon_of(cnt_q)),
    .rk_o   (step_out)
  );

  // FSM next state, counter and store updates, status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    store_d    = store_q;
    key_ready  = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    case (state_q)
      aes_pkg::ST_IDLE, aes_pkg::ST_DONE: begin
        key_ready  = 1'b1;
        keys_valid = (state_q == aes_pkg::ST_DONE);
        if (key_valid) begin
          store_d[0] = key_in;
          cnt_d      = 4'd1;
          state_d    = aes_pkg::ST_EXPAND;
        end
      end
      aes_pkg::ST_EXPAND: begin
        busy = 1'b1;
        for (int i = 1; i < NE; i++)
          if (cnt_q == 4'(i)) store_d[i] = step_out;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NUM_ROUNDS)) state_d = aes_pkg::ST_DONE;
      end
      default: state_d = aes_pkg::ST_IDLE;
    endcase
  end

  // State, counter and store registers; reset clears any partial schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= aes_pkg::ST_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NE; i++) store_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NE; i++) store_q[i] <= store_d[i];
    end
  end

  // Read port: reverse order for decrypt, zero for indices past the last round.
  always_comb begin
    rd_key  = '0;
    eff_idx = rd_dec ? (4'(NUM_ROUNDS) - rd_idx) : rd_idx;
    if (rd_idx <= 4'(NUM_ROUNDS))
      for (int i = 0; i < NE; i++)
        if (eff_idx == 4'(i)) rd_key = store_q[i];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 and all-zero key vectors.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready, busy, keys_valid;
  logic [3:0]   rd_idx;
  logic         rd_dec;
  logic [127:0] rd_key;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] K_FIPS  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] RK1_F   = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] RK10_F  = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] RK1_Z   = 128'h63636362636363626363636263636362;
  localparam logic [127:0] RK10_Z  = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  aes_key_expander dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_dec     (rd_dec),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [3:0] idx, input logic dec, input string tag,
                    input logic [127:0] exp);
    rd_idx = idx;
    rd_dec = dec;
    #1;
    chk(tag, rd_key, exp);
  endtask

  // Accept k at the next edge, then step 10 edges checking the keys_valid timing.
  task automatic expand(input logic [127:0] k, input string tag);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk({tag, "_busy0"}, {127'h0, busy}, 128'h1);
    chk({tag, "_kv0"}, {127'h0, keys_valid}, 128'h0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 9)  chk({tag, "_kv9"}, {127'h0, keys_valid}, 128'h0);
      if (i == 10) chk({tag, "_kv10"}, {127'h0, keys_valid}, 128'h1);
    end
  endtask

  initial begin
    int run;
    logic prev_busy;
    rst = 1'b1; key_in = '0; key_valid = 1'b0; rd_idx = '0; rd_dec = 1'b0;
    #12;
    chk("rst_ready", {127'h0, key_ready}, 128'h1);
    chk("rst_busy",  {127'h0, busy}, 128'h0);
    chk("rst_kv",    {127'h0, keys_valid}, 128'h0);
    rd(4'd0, 1'b0, "rst_rd0", 128'h0);
    @(negedge clk); rst = 1'b0;

    // First FIPS expansion, with an ignored key_valid pulse mid-expansion.
    @(negedge clk);
    key_in = K_FIPS; key_valid = 1'b1;
    @(posedge clk); #1; key_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin
        @(negedge clk); key_in = '1; key_valid = 1'b1;
        chk("exp_ready", {127'h0, key_ready}, 128'h0);
      end
      @(posedge clk); #1; key_valid = 1'b0;
      if (i == 9)  chk("v1_kv9", {127'h0, keys_valid}, 128'h0);
      if (i == 10) chk("v1_kv10", {127'h0, keys_valid}, 128'h1);
    end
    rd(4'd1,  1'b0, "fwd_rk1",  RK1_F);
    rd(4'd10, 1'b0, "fwd_rk10", RK10_F);
    rd(4'd0,  1'b0, "fwd_rk0",  K_FIPS);
    rd(4'd0,  1'b1, "dec_i0",   RK10_F);
    rd(4'd10, 1'b1, "dec_i10",  K_FIPS);
    rd(4'd9,  1'b1, "dec_i9",   RK1_F);
    for (int i = 11; i < 16; i++) begin
      rd(4'(i), 1'b0, "oob_fwd", 128'h0);
      rd(4'(i), 1'b1, "oob_dec", 128'h0);
    end

    // Rekey with the all-zero key from DONE.
    expand(128'h0, "zero");
    rd(4'd10, 1'b0, "zero_rk10", RK10_Z);
    rd(4'd1,  1'b0, "zero_rk1",  RK1_Z);
    rd(4'd0,  1'b1, "zero_dec0", RK10_Z);

    // Reset four cycles after accept.
    @(negedge clk);
    key_in = K_FIPS; key_valid = 1'b1;
    @(posedge clk); #1; key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("mid_busy",  {127'h0, busy}, 128'h0);
    chk("mid_kv",    {127'h0, keys_valid}, 128'h0);
    chk("mid_ready", {127'h0, key_ready}, 128'h1);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 1'b0, "mid_rd_fwd", 128'h0);
      rd(4'(i), 1'b1, "mid_rd_dec", 128'h0);
    end
    @(negedge clk); rst = 1'b0;
    expand(K_FIPS, "post");
    rd(4'd10, 1'b0, "post_rk10", RK10_F);
    rd(4'd1,  1'b0, "post_rk1",  RK1_F);

    // Back-to-back: key_valid held high, busy runs must be exactly 10 cycles.
    @(negedge clk);
    key_in = K_FIPS; key_valid = 1'b1;
    run = 0; prev_busy = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
      chk("b2b_excl", {127'h0, busy & key_ready}, 128'h0);
      if (busy) run++;
      else if (prev_busy) begin
        chk("b2b_run", 128'(run), 128'd10);
        run = 0;
      end
      prev_busy = busy;
    end
    key_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_kv", {127'h0, keys_valid}, 128'h1);
    rd(4'd10, 1'b0, "b2b_rk10", RK10_F);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequential AES-128 key schedule. Accepts one cipher key and produces round keys 0..10, one per clock, into an internal 11-entry round-key store.
- Provides a combinational read port that the round datapath indexes per round, in forward order for encryption or reverse order for decryption.
- Sits beside the single-round AES datapath as the producer of its 128-bit key operand.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; the store holds NUM_ROUNDS+1 entries. Only 10 (AES-128) is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_in  in  128  cipher key.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  block can accept a key.
- busy  out  1  expansion in progress.
- keys_valid  out  1  all 11 round keys are stored and stable.
- rd_idx  in  4  round number requested by the datapath.
- rd_dec  in  1  0 = forward order, 1 = reverse (decrypt) order.
- rd_key  out  128  selected round key, combinational.

Behaviour:
- Byte order matches the round datapath:
  - word i = bits [32i+31:32i];
  - byte j of a word = bits [8j+7:8j];
  - byte 0 of word 0 is key_in[7:0].
- Reset (async, rst=1):
  - state = IDLE, key_ready=1, busy=0, keys_valid=0;
  - all store entries = 0, round counter = 0.
- FSM states:
  - IDLE: key_ready=1. On key_valid&&key_ready, store[0]<=key_in, counter<=1, go to EXPAND.
  - EXPAND: key_ready=0, busy=1. Each cycle store[counter]<=step(store[counter-1], rcon[counter]) and counter increments. The cycle that writes store[10] moves to DONE.
  - DONE: keys_valid=1, key_ready=1. A new key_valid accepts the key exactly as in IDLE: store[0] is overwritten, keys_valid drops at that edge, and the FSM goes to EXPAND.
- Latency: with the accept edge at T0, rk1..rk10 are written at T1..T10, and keys_valid=1 from the T10 edge onward (10 cycles after acceptance).
- key_valid is ignored while in EXPAND; no queuing.
- Step function (AES-128):
  - t = SubWord(RotWord(w3)) ^ rcon, where RotWord = {w3[7:0], w3[31:8]} and rcon is XORed into bits [7:0];
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Read port:
  - effective index e = rd_dec ? (10 - rd_idx) : rd_idx;
  - rd_key = store[e] for rd_idx 0..10;
  - rd_key = 0 for rd_idx 11..15 in either mode;
  - rd_key is not gated by keys_valid. The consumer must wait for keys_valid.
- Decrypt keys are the plain round keys in reverse order; InvMixColumns is not applied, because the datapath applies AddRoundKey before InvMixColumns.
- Reset mid-EXPAND: immediate return to the reset state. The partial schedule is cleared.

Decomposition:
- Shared package aes_pkg: NUM_ROUNDS, the RCON table (10 x 8-bit), and the byte/word index convention constants.
- One sub-module, aes_key_step: combinational 128-bit to 128-bit next-round-key function with rcon input and 4 instances of the existing forward sbox.
- The FSM, counter and store stay in aes_key_expander.

Test Plan:
- FIPS-197 key, vector 1: key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b pulsed for one cycle -> keys_valid rises exactly 10 cycles after the accept edge. rd_idx=1, rd_dec=0 -> rd_key=128'h05766c2a3939a323b12c548817fefaa0.
- FIPS-197 key, vector 2: same key, rd_idx=10, rd_dec=0 -> rd_key=128'ha60c63b6c80c3fe18925eec9a8f914d0.
- Reverse read: same schedule, rd_dec=1 -> rd_idx=0 returns the rk10 value above, rd_idx=10 returns key_in. Any rd_idx 11..15 with either rd_dec -> rd_key=0.
- Reset mid-expansion: assert rst 4 cycles after accept -> the same cycle shows busy=0, keys_valid=0, key_ready=1 and rd_key=0 for every rd_idx. After release, a full expansion completes normally.
- Rekey: key_valid pulsed during EXPAND is ignored, and the schedule still matches the first key. All-zero key accepted in DONE -> keys_valid=0 the next cycle, then rk10=FIPS-197 all-zero-key value reordered to LSB-byte-first, 10 cycles later.
- Back-to-back: key_valid held high continuously -> a key is accepted only in IDLE/DONE, busy=1 for exactly 10 cycles per expansion, and key_ready is never high while busy is high.
